// File: rtl/i2c_timer_pkg.sv
// Shared types for the I2C slave frame timer: FSM state encoding and
// the bit-index width helper.
package i2c_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_BYTE_DONE,
    ST_WAIT_FALL,
    ST_ACK_SLOT,
    ST_ACK_HOLD,
    ST_ACK_END,
    ST_WAIT_STOP
  } i2c_tstate_t;

  function automatic int unsigned bit_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2c_frame_timer.sv
// I2C slave frame timer: counts data bits between START and STOP and
// sequences the ACK slot for slave-receive and slave-transmit frames.
module i2c_frame_timer
  import i2c_timer_pkg::*;
#(
  parameter  int unsigned DATA_BITS  = 8,
  parameter  int unsigned FCNT_WIDTH = 8,
  localparam int unsigned BIT_W      = bit_w(DATA_BITS)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  rising_edge_found,
  input  logic                  falling_edge_found,
  input  logic                  start_found,
  input  logic                  stop_found,
  input  logic                  tx_mode,
  input  logic                  sda_in,
  output logic                  bit_strobe,
  output logic [BIT_W-1:0]      bit_index,
  output logic                  byte_received,
  output logic                  ack_prep,
  output logic                  check_ack,
  output logic                  ack_done,
  output logic                  nack_detected,
  output logic [FCNT_WIDTH-1:0] frame_count,
  output logic                  busy
);

  i2c_tstate_t           state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  nack_q, nack_d;
  logic                  rise, fall;

  // A coincident rise wins; the simultaneous fall is discarded.
  assign rise = rising_edge_found;
  assign fall = falling_edge_found & ~rising_edge_found;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      fcnt_q  <= '0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      fcnt_q  <= fcnt_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    fcnt_d        = fcnt_q;
    nack_d        = nack_q;
    bit_strobe    = 1'b0;
    byte_received = 1'b0;
    ack_prep      = 1'b0;
    check_ack     = 1'b0;
    ack_done      = 1'b0;
    nack_detected = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_DATA: begin
        if (rise) begin
          bit_strobe = 1'b1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = ST_BYTE_DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BYTE_DONE: begin
        byte_received = 1'b1;
        state_d       = fall ? ST_ACK_SLOT : ST_WAIT_FALL;
      end
      ST_WAIT_FALL: begin
        if (fall) state_d = ST_ACK_SLOT;
      end
      ST_ACK_SLOT: begin
        ack_prep = ~tx_mode;
        if (rise) begin
          check_ack = 1'b1;
          nack_d    = tx_mode & sda_in;
          state_d   = ST_ACK_HOLD;
        end
      end
      ST_ACK_HOLD: begin
        ack_prep = ~tx_mode;
        if (fall) state_d = ST_ACK_END;
      end
      ST_ACK_END: begin
        ack_done = 1'b1;
        if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
        if (nack_q) begin
          nack_detected = 1'b1;
          nack_d        = 1'b0;
          state_d       = ST_WAIT_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_WAIT_STOP: ;
      default: state_d = ST_IDLE;
    endcase

    // START/STOP override the per-state transition, so the edge-qualified
    // Mealy pulses of that transition are suppressed with it.
    if (start_found) begin
      state_d    = ST_DATA;
      bit_d      = '0;
      fcnt_d     = '0;
      nack_d     = 1'b0;
      bit_strobe = 1'b0;
      check_ack  = 1'b0;
    end
    if (stop_found) begin
      state_d    = ST_IDLE;
      bit_d      = '0;
      nack_d     = 1'b0;
      bit_strobe = 1'b0;
      check_ack  = 1'b0;
    end
  end

  assign bit_index   = bit_q;
  assign frame_count = fcnt_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Scoreboard bench for i2c_frame_timer: directed frames push expected
// events; a negedge monitor pops and compares as the DUT emits them.
module tb_i2c_frame_timer;

  localparam int K_FCNT = 0, K_STROBE = 1, K_BYTE = 2, K_PREP = 3,
                 K_CHECK = 4, K_ACKDONE = 5, K_NACK = 6;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst_a, n_rst_b, rise, fall, start, stop, tx_mode, sda_in, sel;

  logic       a_strobe, a_byte, a_prep, a_check, a_done, a_nack, a_busy;
  logic [2:0] a_idx;
  logic [7:0] a_fcnt;
  logic       b_strobe, b_byte, b_prep, b_check, b_done, b_nack, b_busy;
  logic [1:0] b_idx;
  logic [1:0] b_fcnt;

  i2c_frame_timer #(.DATA_BITS(8), .FCNT_WIDTH(8)) dut_a (
    .clk(clk), .n_rst(n_rst_a),
    .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop),
    .tx_mode(tx_mode), .sda_in(sda_in),
    .bit_strobe(a_strobe), .bit_index(a_idx), .byte_received(a_byte),
    .ack_prep(a_prep), .check_ack(a_check), .ack_done(a_done),
    .nack_detected(a_nack), .frame_count(a_fcnt), .busy(a_busy)
  );

  i2c_frame_timer #(.DATA_BITS(4), .FCNT_WIDTH(2)) dut_b (
    .clk(clk), .n_rst(n_rst_b),
    .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop),
    .tx_mode(tx_mode), .sda_in(sda_in),
    .bit_strobe(b_strobe), .bit_index(b_idx), .byte_received(b_byte),
    .ack_prep(b_prep), .check_ack(b_check), .ack_done(b_done),
    .nack_detected(b_nack), .frame_count(b_fcnt), .busy(b_busy)
  );

  // The inactive instance is held in reset, so the monitor follows one DUT.
  logic       m_strobe, m_byte, m_prep, m_check, m_done, m_nack;
  logic [7:0] m_idx, m_fcnt;
  assign m_strobe = sel ? b_strobe : a_strobe;
  assign m_byte   = sel ? b_byte   : a_byte;
  assign m_prep   = sel ? b_prep   : a_prep;
  assign m_check  = sel ? b_check  : a_check;
  assign m_done   = sel ? b_done   : a_done;
  assign m_nack   = sel ? b_nack   : a_nack;
  assign m_idx    = sel ? {6'd0, b_idx}  : {5'd0, a_idx};
  assign m_fcnt   = sel ? {6'd0, b_fcnt} : a_fcnt;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];

  function automatic string kname(input int k);
    case (k)
      K_FCNT:    return "frame_count";
      K_STROBE:  return "bit_strobe/bit_index";
      K_BYTE:    return "byte_received";
      K_PREP:    return "ack_prep";
      K_CHECK:   return "check_ack";
      K_ACKDONE: return "ack_done/nack_detected";
      default:   return "nack_detected";
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input int k, input int v);
    exp_q.push_back('{kind: k, val: v});
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected %s: got value %0d expected no event (t=%0t)",
               kname(k), v, $time);
    end else begin
      e = exp_q.pop_front();
      cmp("event order", k, e.kind);
      if (k == e.kind) cmp(kname(k), v, e.val);
    end
  endtask

  logic fcnt_pend = 1'b0;
  logic prev_prep = 1'b0;

  always @(negedge clk) begin
    if (fcnt_pend) observe(K_FCNT, int'(m_fcnt));
    fcnt_pend = m_done;
    if (m_strobe) observe(K_STROBE, int'(m_idx));
    if (m_byte) observe(K_BYTE, 0);
    if (m_prep != prev_prep) observe(K_PREP, int'(m_prep));
    prev_prep = m_prep;
    if (m_check) observe(K_CHECK, 0);
    if (m_done) observe(K_ACKDONE, int'(m_nack));
    else if (m_nack) observe(K_NACK, 1);
  end

  task automatic step(input logic r, input logic f, input logic s, input logic p);
    rise = r; fall = f; start = s; stop = p;
    @(posedge clk); #1;
    rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic scl(input logic d);
    sda_in = d;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Data bits plus the ACK slot; fcnt_exp is the count after this frame.
  task automatic frame(input int nbits, input logic tx, input logic ack_sda,
                       input int fcnt_exp);
    tx_mode = tx;
    for (int i = 0; i < nbits; i++) expect_ev(K_STROBE, i);
    expect_ev(K_BYTE, 0);
    if (!tx) expect_ev(K_PREP, 1);
    expect_ev(K_CHECK, 0);
    if (!tx) expect_ev(K_PREP, 0);
    expect_ev(K_ACKDONE, int'(tx & ack_sda));
    expect_ev(K_FCNT, fcnt_exp);
    for (int i = 0; i < nbits; i++) scl(1'(i % 2));
    scl(ack_sda);
  endtask

  // Runs the data bits of a receive frame, leaving the DUT in the ACK slot.
  task automatic bits_to_ack_slot(input int nbits);
    tx_mode = 1'b0;
    for (int i = 0; i < nbits; i++) expect_ev(K_STROBE, i);
    expect_ev(K_BYTE, 0);
    expect_ev(K_PREP, 1);
    for (int i = 0; i < nbits; i++) scl(1'(i % 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst_a = 1'b0; n_rst_b = 1'b0; sel = 1'b0;
    rise = 1'b0; fall = 1'b0; start = 1'b0; stop = 1'b0;
    tx_mode = 1'b0; sda_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset busy", int'(a_busy), 0);
    cmp("reset frame_count", int'(a_fcnt), 0);
    cmp("reset bit_index", int'(a_idx), 0);
    cmp("reset ack_prep", int'(a_prep), 0);
    n_rst_a = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Receive frame with slave ACK
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("busy after start", int'(a_busy), 1);
    cmp("bit_index after start", int'(a_idx), 0);
    frame(8, 1'b0, 1'b0, 1);

    // Transmit frame, master NACKs; later edges ignored until STOP
    frame(8, 1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) scl(1'b0);
    cmp("busy in wait_stop", int'(a_busy), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("busy after stop", int'(a_busy), 0);
    cmp("frame_count kept after stop", int'(a_fcnt), 2);

    // Repeated START after 5 bits
    step(1'b0, 1'b0, 1'b1, 1'b0);
    frame(8, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) expect_ev(K_STROBE, i);
    for (int i = 0; i < 5; i++) scl(1'b1);
    cmp("bit_index mid-byte", int'(a_idx), 5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    cmp("restart bit_index", int'(a_idx), 0);
    cmp("restart frame_count", int'(a_fcnt), 0);
    cmp("restart busy", int'(a_busy), 1);
    frame(8, 1'b0, 1'b0, 1);

    // STOP while in ACK_HOLD
    bits_to_ack_slot(8);
    expect_ev(K_CHECK, 0);
    expect_ev(K_PREP, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    cmp("ack_prep after stop", int'(a_prep), 0);
    cmp("busy after stop in ack_hold", int'(a_busy), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during the ACK slot
    step(1'b0, 1'b0, 1'b1, 1'b0);
    frame(8, 1'b0, 1'b0, 1);
    bits_to_ack_slot(8);
    expect_ev(K_PREP, 0);
    cmp("ack_prep before reset", int'(a_prep), 1);
    #2 n_rst_a = 1'b0;
    #1;
    cmp("async reset ack_prep", int'(a_prep), 0);
    cmp("async reset busy", int'(a_busy), 0);
    cmp("async reset frame_count", int'(a_fcnt), 0);
    @(posedge clk); #1;
    n_rst_a = 1'b1;
    for (int i = 0; i < 3; i++) scl(1'b0);
    cmp("idle after reset busy", int'(a_busy), 0);
    cmp("idle after reset bit_index", int'(a_idx), 0);

    // DATA_BITS=4, FCNT_WIDTH=2: saturating frame counter
    n_rst_a = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    sel = 1'b1;
    n_rst_b = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) frame(4, 1'b0, 1'b0, (k < 3) ? k : 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    cmp("small busy after stop", int'(b_busy), 0);
    cmp("small frame_count saturated", int'(b_fcnt), 3);

    cmp("expected events outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
